control_unit_fsm: RTL
=====================

CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 MEM_TIMEOUT, 255, max wait cycles for mem_ready in one memory state before trap (legal 1..255).
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  IR[31:26] from the externally held IR.
REQ-005 funct  input  6  IR[5:0] from the externally held IR.
REQ-006 zeroFlag  input  1  ALU zero flag; the ALU updates it only for codes 100000 and 100010.
REQ-007 mem_ready  input  1  memory completion strobe.
REQ-008 operation  output  6  ALU function code.
REQ-009 alu_src_a  output  1  ALU A mux: 0=PC, 1=rs.
REQ-010 alu_src_b  output  2  ALU B mux: 00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-011 mem_read, mem_write, i_or_d  output  1 each  memory strobes; address mux: 0=PC, 1=ALUOut.
REQ-012 ir_write, pc_write  output  1 each  register enables.
REQ-013 pc_src  output  2  PC mux: 00=ALU result, 01=ALUOut, 10=jump target.
REQ-014 reg_write, reg_dst, mem_to_reg  output  1 each  regfile write enable; dest mux: 0=rt, 1=rd; data mux: 0=ALUOut, 1=MDR.
REQ-015 trap  output  1  sticky illegal-opcode/timeout indicator.
REQ-016 state  output  4  current state encoding (debug).

Function
REQ-017 States and encodings SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, EXEC_I=8, I_WB=9, BRANCH=10, JUMP=11, TRAP=12; codes 13-15 SHALL go to TRAP.
REQ-018 FETCH SHALL assert mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, operation=100001, pc_src=00 and hold them until mem_ready=1.
REQ-019 ir_write and pc_write SHALL be 1 only in the FETCH cycle where mem_ready=1; the next state SHALL be DECODE.
REQ-020 DECODE (1 cycle) SHALL drive alu_src_a=0, alu_src_b=11, operation=100001 for the branch target and dispatch: 100011->MEM_ADDR, 101011->MEM_ADDR, 000000->EXEC_R, 001001->EXEC_I, 000100/000101->BRANCH, 000010->JUMP, any other->TRAP.
REQ-021 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, operation=100001, then go to MEM_RD for opcode 100011 and MEM_WR for 101011.
REQ-022 MEM_RD/MEM_WR SHALL hold i_or_d=1 plus mem_read/mem_write until mem_ready=1; MEM_RD->MEM_WB, MEM_WR->FETCH.
REQ-023 MEM_WB SHALL assert reg_write=1, reg_dst=0, mem_to_reg=1 for 1 cycle, then FETCH.
REQ-024 EXEC_R SHALL drive operation=funct, alu_src_a=1, alu_src_b=00, then R_WB with reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
REQ-025 EXEC_I SHALL drive operation=100001, alu_src_a=1, alu_src_b=10, then I_WB with reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
REQ-026 BRANCH SHALL drive operation=100010 (signed subtract, so zeroFlag updates), alu_src_a=1, alu_src_b=00, pc_src=01.
REQ-027 In BRANCH, pc_write SHALL equal zeroFlag for 000100 and ~zeroFlag for 000101, sampled combinationally in the same cycle; next state FETCH.
REQ-028 JUMP SHALL assert pc_src=10, pc_write=1 for 1 cycle, then FETCH.
REQ-029 An 8-bit wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle there with mem_ready=0.
REQ-030 When the counter reaches MEM_TIMEOUT with mem_ready=0, the next state SHALL be TRAP; mem_ready=1 in that same cycle SHALL win.
REQ-031 TRAP SHALL set trap=1 with all strobes and enables 0, and SHALL stay in TRAP until reset.
REQ-032 Any strobe or enable not listed for a state SHALL be 0 in that state; mux selects not listed SHALL be 0.
REQ-033 operation SHALL default to 100001 in states not listed above.
REQ-034 All outputs SHALL depend only on state, opcode, funct, zeroFlag and mem_ready, with no other combinational paths.

Reset
REQ-035 reset=1 SHALL immediately, without a clock edge, force state=FETCH, wait counter=0, trap=0.
REQ-036 While reset=1, all enables and strobes SHALL be 0.
REQ-037 After release, the first rising edge SHALL evaluate FETCH normally.
REQ-038 Reset asserted mid-memory-wait SHALL abort the access with no pc_write or reg_write.

Verification
REQ-039 lw (100011), mem_ready high on 3rd FETCH cycle and 1st MEM_RD cycle -> states 0,0,0,1,2,3,4,0; reg_write=1 only in state 4.
REQ-040 R-type funct=100100 -> operation=100100 in EXEC_R, reg_dst=1 in R_WB, total 4 cycles with mem_ready constantly 1.
REQ-041 beq with zeroFlag=1 -> pc_write=1 in BRANCH; bne with zeroFlag=1 -> pc_write=0; operation=100010 in both.
REQ-042 opcode 111111 -> DECODE->TRAP, trap=1 held 100 cycles, then reset clears trap asynchronously.
REQ-043 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 wait cycles; repeat with mem_ready=1 on 4th cycle -> DECODE.
REQ-044 reset pulsed mid-MEM_WR -> state=0 before next edge, mem_write=0, no pc_write.

Source files
------------

// File: rtl/control_unit_fsm.sv
// Multi-cycle MIPS-style control unit: sequences fetch/decode/execute/memory/writeback
// and traps on illegal opcodes or memory handshakes that exceed MEM_TIMEOUT cycles.
module control_unit_fsm #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zeroFlag,
   input  logic       mem_ready,
   output logic [5:0] operation,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       trap,
   output logic [3:0] state
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEM_ADDR = 4'd2;
   localparam logic [3:0] MEM_RD   = 4'd3;
   localparam logic [3:0] MEM_WB   = 4'd4;
   localparam logic [3:0] MEM_WR   = 4'd5;
   localparam logic [3:0] EXEC_R   = 4'd6;
   localparam logic [3:0] R_WB     = 4'd7;
   localparam logic [3:0] EXEC_I   = 4'd8;
   localparam logic [3:0] I_WB     = 4'd9;
   localparam logic [3:0] BRANCH   = 4'd10;
   localparam logic [3:0] JUMP     = 4'd11;
   localparam logic [3:0] TRAP     = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] ALU_ADD  = 6'b100001;
   localparam logic [5:0] ALU_SUB  = 6'b100010;

   // waitCnt holds cycles already waited, so the MEM_TIMEOUT-th idle cycle is the one that traps
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   logic [3:0] nextState;
   logic [7:0] waitCnt;
   logic       memWait;
   logic       timeout;

   always_comb begin
      memWait = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
      timeout = memWait && !mem_ready && (waitCnt == TMO_LAST);
   end

   always_comb begin
      nextState = state;
      case (state)
         FETCH:    nextState = mem_ready ? DECODE : (timeout ? TRAP : FETCH);
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW:   nextState = MEM_ADDR;
               OP_RTYPE:       nextState = EXEC_R;
               OP_ADDIU:       nextState = EXEC_I;
               OP_BEQ, OP_BNE: nextState = BRANCH;
               OP_J:           nextState = JUMP;
               default:        nextState = TRAP;
            endcase
         end
         MEM_ADDR: nextState = (opcode == OP_LW) ? MEM_RD : ((opcode == OP_SW) ? MEM_WR : TRAP);
         MEM_RD:   nextState = mem_ready ? MEM_WB : (timeout ? TRAP : MEM_RD);
         MEM_WR:   nextState = mem_ready ? FETCH : (timeout ? TRAP : MEM_WR);
         EXEC_R:   nextState = R_WB;
         EXEC_I:   nextState = I_WB;
         MEM_WB, R_WB, I_WB, BRANCH, JUMP: nextState = FETCH;
         TRAP:     nextState = TRAP;
         default:  nextState = TRAP;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         waitCnt <= '0;
      end else begin
         state   <= nextState;
         waitCnt <= (memWait && nextState == state) ? waitCnt + 8'd1 : '0;
      end
   end

   always_comb begin
      operation  = ALU_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      trap       = 1'b0;
      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE:   alu_src_b = 2'b11;
         MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
         MEM_RD:   begin i_or_d = 1'b1; mem_read = 1'b1; end
         MEM_WB:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
         MEM_WR:   begin i_or_d = 1'b1; mem_write = 1'b1; end
         EXEC_R:   begin operation = funct; alu_src_a = 1'b1; end
         R_WB:     begin reg_write = 1'b1; reg_dst = 1'b1; end
         EXEC_I:   begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
         I_WB:     reg_write = 1'b1;
         BRANCH: begin
            operation = ALU_SUB;
            alu_src_a = 1'b1;
            pc_src    = 2'b01;
            pc_write  = (opcode == OP_BEQ) ? zeroFlag : ((opcode == OP_BNE) ? ~zeroFlag : 1'b0);
         end
         JUMP:     begin pc_src = 2'b10; pc_write = 1'b1; end
         TRAP:     trap = 1'b1;
         default: ;
      endcase
      // reset forces FETCH, whose strobes must still stay quiet until release
      if (reset) begin
         mem_read  = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         reg_write = 1'b0;
      end
   end

endmodule
